// File: rtl/eql_cont_gen.sv
// Front end for the interrupt-handler FSM: synchronises the external request into eql
// and runs the enable-gated limit counter that produces cont_eql, plus a sticky overrun flag.
module eql_cont_gen #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] LIMIT_RST = WIDTH'(5),
   parameter logic [1:0]       CC_ACKIN  = 2'b11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_in,
   input  logic             enable_count,
   input  logic [1:0]       cc_mux,
   input  logic             lim_load,
   input  logic [WIDTH-1:0] lim_data,
   output logic             eql,
   output logic             cont_eql,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             eql_q, eql_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             cont_eql_q, cont_eql_d;
   logic             ovf_q, ovf_d;
   logic             ack;
   logic             at_limit;

   always_comb begin
      ack      = (cc_mux == CC_ACKIN);
      at_limit = (cnt_q >= lim_q);

      sync1_d = req_in;
      sync2_d = sync1_q;
      eql_d   = sync2_q;

      lim_d = lim_load ? lim_data : lim_q;

      cnt_d = cnt_q;
      ovf_d = ovf_q;
      // The acknowledge clear dominates, so an enable in the same cycle never flags overrun.
      if (ack) begin
         cnt_d = '0;
      end else if (enable_count) begin
         if (!at_limit) begin
            cnt_d = cnt_q + WIDTH'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      // Compare against next-state values so cont_eql lines up with the updated cnt.
      cont_eql_d = (cnt_d == lim_d);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         eql_q      <= 1'b0;
         cnt_q      <= '0;
         lim_q      <= LIMIT_RST;
         cont_eql_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         eql_q      <= eql_d;
         cnt_q      <= cnt_d;
         lim_q      <= lim_d;
         cont_eql_q <= cont_eql_d;
         ovf_q      <= ovf_d;
      end
   end

   assign eql      = eql_q;
   assign cont_eql = cont_eql_q;
   assign cnt      = cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_eql_cont_gen.sv
// Self-checking bench for eql_cont_gen: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_eql_cont_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_in = 1'b0;
   logic       enable_count = 1'b0;
   logic [1:0] cc_mux = 2'b00;
   logic       lim_load = 1'b0;
   logic [3:0] lim_data = 4'd0;
   logic       eql;
   logic       cont_eql;
   logic [3:0] cnt;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_cnt, m_lim, m_ovf, m_ce, m_eql;
   bit req_hist[$];

   eql_cont_gen dut (
      .clock        (clock),
      .reset        (reset),
      .req_in       (req_in),
      .enable_count (enable_count),
      .cc_mux       (cc_mux),
      .lim_load     (lim_load),
      .lim_data     (lim_data),
      .eql          (eql),
      .cont_eql     (cont_eql),
      .cnt          (cnt),
      .ovf          (ovf)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0;
      m_lim = 5;
      m_ovf = 0;
      m_ce  = 0;
      m_eql = 0;
      req_hist.delete();
      req_hist.push_back(1'b0);
      req_hist.push_back(1'b0);
   endfunction

   // One clock edge of the specified behaviour, using the inputs held before the edge.
   function automatic void model_step();
      int nxt, nlim;
      bit ack;
      ack = (cc_mux == 2'b11);
      if (ack)                                nxt = 0;
      else if (enable_count && m_cnt < m_lim) nxt = m_cnt + 1;
      else                                    nxt = m_cnt;
      if (!ack && enable_count && m_cnt >= m_lim) m_ovf = 1;
      nlim  = lim_load ? int'(lim_data) : m_lim;
      m_ce  = (nxt == nlim) ? 1 : 0;
      m_cnt = nxt;
      m_lim = nlim;
      req_hist.push_back(req_in);
      m_eql = int'(req_hist.pop_front());
   endfunction

   task automatic compare_all();
      check("eql", int'(eql), m_eql);
      check("cont_eql", int'(cont_eql), m_ce);
      check("cnt", int'(cnt), m_cnt);
      check("ovf", int'(ovf), m_ovf);
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) model_reset();
      else        model_step();
      #1;
      compare_all();
   endtask

   // Asserts reset between edges, checks the immediate clear, holds for one edge, releases.
   task automatic reset_pulse();
      #2 reset = 1'b0;
      #1;
      check("rst_eql", int'(eql), 0);
      check("rst_cnt", int'(cnt), 0);
      check("rst_ce", int'(cont_eql), 0);
      check("rst_ovf", int'(ovf), 0);
      model_reset();
      tick();
      #2 reset = 1'b1;
   endtask

   initial begin
      // power-on reset
      #1 reset = 1'b0;
      model_reset();
      #2;
      check("por_eql", int'(eql), 0);
      check("por_cnt", int'(cnt), 0);
      check("por_ce", int'(cont_eql), 0);
      check("por_ovf", int'(ovf), 0);
      #9 reset = 1'b1;
      tick();

      // request synchroniser latency
      req_in = 1'b1;
      tick();
      tick();
      check("eql_lat2", int'(eql), 0);
      tick();
      check("eql_lat3", int'(eql), 1);

      // count up to the reset limit of 5, then one more enable
      enable_count = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("up_cnt", int'(cnt), i);
         check("up_ce", int'(cont_eql), (i == 5) ? 1 : 0);
      end
      check("up_ovf", int'(ovf), 0);
      tick();
      check("sat_cnt", int'(cnt), 5);
      check("sat_ovf", int'(ovf), 1);

      // acknowledge clear overrides enable
      enable_count = 1'b0;
      cc_mux = 2'b11;
      tick();
      check("ack_cnt0", int'(cnt), 0);
      cc_mux = 2'b00;
      enable_count = 1'b1;
      tick(); tick(); tick();
      check("pre_ack_cnt", int'(cnt), 3);
      cc_mux = 2'b11;
      tick();
      check("ack_en_cnt", int'(cnt), 0);
      check("ack_en_ce", int'(cont_eql), 0);
      check("ack_en_ovf", int'(ovf), 1);
      cc_mux = 2'b01;
      tick();
      check("post_ack_cnt", int'(cnt), 1);

      // clear ovf so the lowered-limit case is observable
      enable_count = 1'b0;
      cc_mux = 2'b00;
      reset_pulse();

      // limit lowered below the current count
      enable_count = 1'b1;
      tick(); tick(); tick(); tick();
      check("low_pre_cnt", int'(cnt), 4);
      check("low_pre_ovf", int'(ovf), 0);
      enable_count = 1'b0;
      lim_load = 1'b1;
      lim_data = 4'd2;
      tick();
      check("low_ld_cnt", int'(cnt), 4);
      check("low_ld_ce", int'(cont_eql), 0);
      lim_load = 1'b0;
      enable_count = 1'b1;
      tick();
      check("low_sat_cnt", int'(cnt), 4);
      check("low_sat_ce", int'(cont_eql), 0);
      check("low_sat_ovf", int'(ovf), 1);
      enable_count = 1'b0;
      cc_mux = 2'b11;
      tick();
      check("low_ack_cnt", int'(cnt), 0);
      cc_mux = 2'b00;
      enable_count = 1'b1;
      tick();
      check("low_c1_ce", int'(cont_eql), 0);
      tick();
      check("low_c2_cnt", int'(cnt), 2);
      check("low_c2_ce", int'(cont_eql), 1);

      // zero limit loaded together with acknowledge
      enable_count = 1'b0;
      cc_mux = 2'b11;
      lim_load = 1'b1;
      lim_data = 4'd0;
      tick();
      check("zero_cnt", int'(cnt), 0);
      check("zero_ce", int'(cont_eql), 1);

      // mid-count reset with a non-default limit; afterwards limit must be back to 5
      lim_data = 4'd7;
      tick();
      check("l7_ce", int'(cont_eql), 0);
      lim_load = 1'b0;
      cc_mux = 2'b00;
      enable_count = 1'b1;
      tick(); tick(); tick();
      check("mid_cnt", int'(cnt), 3);
      check("mid_eql", int'(eql), 1);
      check("mid_ovf", int'(ovf), 1);
      enable_count = 1'b0;
      reset_pulse();
      enable_count = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("rel_ce", int'(cont_eql), (i == 5) ? 1 : 0);
      end
      check("rel_cnt", int'(cnt), 5);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) req_in = ~req_in;
         enable_count = ($urandom_range(0, 9) < 7);
         cc_mux = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         lim_load = ($urandom_range(0, 19) == 0);
         lim_data = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) reset_pulse();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
